// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Circular buffer with write/read pointers and an occupancy count.
module sync_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_hold;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wren & ~w_full;
    assign w_rd_acc = rden & ~w_empty;
    assign w_head   = r_mem[r_rd_ptr];

    assign full   = w_full;
    assign empty  = w_empty;
    // While empty, keep showing the last head seen (zero after reset).
    assign o_data = w_empty ? r_hold : w_head;

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Write pointer advances on each accepted write, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
        end
    end

    // Read pointer advances on each accepted read, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy count: unchanged when a read and a write both land.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Track the visible head so o_data is stable once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (!w_empty) begin
            r_hold <= w_head;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wren;
    logic       rden;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       full;
    logic       empty;

    int vectors = 0;
    int miscompares = 0;

    sync_fifo #(
        .DEPTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wren  (wren),
        .rden  (rden),
        .i_data(i_data),
        .o_data(o_data),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        wren = 1'b0;
        rden = 1'b0;
        i_data = 8'h00;

        // Reset held for two edges, then released.
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_empty", {7'd0, empty}, 8'd1);
        check("rst_full", {7'd0, full}, 8'd0);
        check("rst_data", o_data, 8'h00);

        // Fill with 10..80.
        for (int i = 1; i <= 8; i++) begin
            wren = 1'b1;
            i_data = 8'(i * 10);
            step();
            check("fill_empty", {7'd0, empty}, 8'd0);
            check("fill_full", {7'd0, full}, (i == 8) ? 8'd1 : 8'd0);
            check("fill_head", o_data, 8'd10);
        end

        // Overflow write of 90 is dropped.
        i_data = 8'd90;
        step();
        wren = 1'b0;
        check("ovf_full", {7'd0, full}, 8'd1);
        check("ovf_head", o_data, 8'd10);

        // Drain in order.
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", o_data, 8'(i * 10));
            rden = 1'b1;
            step();
        end
        check("drain_empty", {7'd0, empty}, 8'd1);
        check("drain_full", {7'd0, full}, 8'd0);
        check("drain_hold", o_data, 8'd80);

        // Ninth read changes nothing.
        step();
        rden = 1'b0;
        check("udf_empty", {7'd0, empty}, 8'd1);
        check("udf_hold", o_data, 8'd80);

        // Wrap-around: move pointers to 5, then fill with 1..8.
        for (int i = 0; i < 5; i++) begin
            wren = 1'b1;
            i_data = 8'(8'hA0 + i);
            step();
        end
        wren = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("wrap_pre", o_data, 8'(8'hA0 + i));
            rden = 1'b1;
            step();
        end
        rden = 1'b0;
        check("wrap_pre_empty", {7'd0, empty}, 8'd1);
        for (int i = 1; i <= 8; i++) begin
            wren = 1'b1;
            i_data = 8'(i);
            step();
        end
        wren = 1'b0;
        check("wrap_full", {7'd0, full}, 8'd1);
        for (int i = 1; i <= 8; i++) begin
            check("wrap_data", o_data, 8'(i));
            rden = 1'b1;
            step();
        end
        rden = 1'b0;
        check("wrap_empty", {7'd0, empty}, 8'd1);

        // Simultaneous traffic with three entries stored.
        for (int i = 0; i < 3; i++) begin
            wren = 1'b1;
            i_data = 8'(8'h30 + i);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            check("sim_head", o_data, 8'(8'h30 + k));
            wren = 1'b1;
            rden = 1'b1;
            i_data = 8'(8'h33 + k);
            step();
            check("sim_empty", {7'd0, empty}, 8'd0);
            check("sim_full", {7'd0, full}, 8'd0);
        end
        wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sim_drain", o_data, 8'(8'h3A + i));
            rden = 1'b1;
            step();
        end
        rden = 1'b0;
        check("sim_end_empty", {7'd0, empty}, 8'd1);

        // Full with both requests: only the read is accepted.
        for (int i = 0; i < 8; i++) begin
            wren = 1'b1;
            i_data = 8'(8'h40 + i);
            step();
        end
        check("fb_full", {7'd0, full}, 8'd1);
        rden = 1'b1;
        i_data = 8'h48;
        step();
        rden = 1'b0;
        check("fb_notfull", {7'd0, full}, 8'd0);
        check("fb_head", o_data, 8'h41);
        i_data = 8'h49;
        step();
        wren = 1'b0;
        check("fb_refull", {7'd0, full}, 8'd1);
        for (int i = 0; i < 8; i++) begin
            check("fb_drain", o_data, (i == 7) ? 8'h49 : 8'(8'h41 + i));
            rden = 1'b1;
            step();
        end
        rden = 1'b0;
        check("fb_empty", {7'd0, empty}, 8'd1);

        // Empty with both requests: only the write is accepted.
        wren = 1'b1;
        rden = 1'b1;
        i_data = 8'h77;
        step();
        wren = 1'b0;
        rden = 1'b0;
        check("eb_empty", {7'd0, empty}, 8'd0);
        check("eb_head", o_data, 8'h77);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("eb_drain", {7'd0, empty}, 8'd1);

        // Mid-operation reset with a write pending.
        for (int i = 0; i < 4; i++) begin
            wren = 1'b1;
            i_data = 8'(8'hC0 + i);
            step();
        end
        rst = 1'b1;
        i_data = 8'hEE;
        step();
        rst = 1'b0;
        wren = 1'b0;
        check("mr_empty", {7'd0, empty}, 8'd1);
        check("mr_full", {7'd0, full}, 8'd0);
        check("mr_data", o_data, 8'h00);
        wren = 1'b1;
        i_data = 8'h55;
        step();
        wren = 1'b0;
        check("mr_wr_empty", {7'd0, empty}, 8'd0);
        check("mr_wr_data", o_data, 8'h55);
        rden = 1'b1;
        step();
        rden = 1'b0;
        check("mr_final_empty", {7'd0, empty}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
